// File: rtl/schedule_multi_if.sv
// Shared types for the schedule stage plus the reservation-station / issue-FIFO
// bundle that connects it to its neighbours.

package schedule_multi_pkg;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned OPT_W   = 4;
    localparam int unsigned IMM_W   = 8;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned DEST_W  = 6;

    typedef logic [ADDR_W-1:0] res_st_addr_t;

    typedef struct packed {
        logic [OPT_W-1:0] optype;
        logic [IMM_W-1:0] imm;
    } op_t;

    // qj/qk are producer tags; zero means the operand is available
    typedef struct packed {
        op_t               op;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic [DEST_W-1:0] dest;
    } res_st_cell_t;
endpackage

interface schedule_multi_if
    import schedule_multi_pkg::*;
#(
    parameter int unsigned WINDOW      = 4,
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned CNT_W       = $clog2(ISSUE_WIDTH + 1)
);
    res_st_addr_t [WINDOW-1:0]      res_st_rd_addr;
    res_st_cell_t [WINDOW-1:0]      res_st_rd_in;
    logic [CNT_W-1:0]               fifo_free;
    logic [ISSUE_WIDTH-1:0]         fifo_wr_en;
    res_st_cell_t [ISSUE_WIDTH-1:0] op_out;
    logic [CNT_W-1:0]               issue_count;

    modport master (
        output res_st_rd_addr, fifo_wr_en, op_out, issue_count,
        input  res_st_rd_in, fifo_free
    );

    modport slave (
        input  res_st_rd_addr, fifo_wr_en, op_out, issue_count,
        output res_st_rd_in, fifo_free
    );
endinterface

// File: rtl/schedule_multi.sv
// Multi-issue select: picks up to ISSUE_WIDTH ready micro-ops from a sliding
// reservation-station window, oldest first, and slides past the issued head.

module schedule_multi
    import schedule_multi_pkg::*;
#(
    parameter int unsigned WINDOW      = 4,
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned CNT_W       = $clog2(ISSUE_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    flush,
    input  res_st_addr_t            flush_ptr,
    schedule_multi_if.master        bus,
    output res_st_addr_t            head_ptr
);
    localparam int unsigned H_W = $clog2(WINDOW + 1);

    res_st_addr_t      rd_ptr_q, rd_ptr_d;
    logic [WINDOW-1:0] issued_q, issued_d;

    logic [WINDOW-1:0] ready_c;
    logic [WINDOW-1:0] granted_c;
    logic [WINDOW-1:0] issued_nx_c;
    logic [CNT_W-1:0]  grant_lim_c;
    logic [CNT_W-1:0]  lane_cnt_c;
    logic [H_W-1:0]    head_adv_c;
    logic              head_stop_c;
    logic              quiet_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            issued_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            issued_q <= issued_d;
        end
    end

    assign head_ptr = rd_ptr_q;

    // window read addresses wrap with the address width
    always_comb begin
        bus.res_st_rd_addr = '0;
        for (int i = 0; i < WINDOW; i++) begin
            bus.res_st_rd_addr[i] = rd_ptr_q + ADDR_W'(i);
        end
    end

    always_comb begin
        ready_c = '0;
        for (int i = 0; i < WINDOW; i++) begin
            ready_c[i] = bus.res_st_rd_in[i].op.optype[0] && !issued_q[i]
                      && (bus.res_st_rd_in[i].qj == '0)
                      && (bus.res_st_rd_in[i].qk == '0);
        end
    end

    assign quiet_c     = rst || flush || !en;
    assign grant_lim_c = (bus.fifo_free > CNT_W'(ISSUE_WIDTH)) ? CNT_W'(ISSUE_WIDTH)
                                                                : bus.fifo_free;

    // lowest-index ready slots fill lanes in order, no gaps
    always_comb begin
        granted_c       = '0;
        lane_cnt_c      = '0;
        bus.fifo_wr_en  = '0;
        bus.op_out      = '0;
        for (int i = 0; i < WINDOW; i++) begin
            if (!quiet_c && ready_c[i] && (lane_cnt_c < grant_lim_c)) begin
                granted_c[i] = 1'b1;
                for (int j = 0; j < ISSUE_WIDTH; j++) begin
                    if (lane_cnt_c == CNT_W'(j)) begin
                        bus.fifo_wr_en[j] = 1'b1;
                        bus.op_out[j]     = bus.res_st_rd_in[i];
                    end
                end
                lane_cnt_c = lane_cnt_c + CNT_W'(1);
            end
        end
        bus.issue_count = lane_cnt_c;
    end

    // count the run of issued slots at the head of the updated vector
    always_comb begin
        issued_nx_c = issued_q | granted_c;
        head_adv_c  = '0;
        head_stop_c = 1'b0;
        for (int i = 0; i < WINDOW; i++) begin
            if (!head_stop_c && issued_nx_c[i]) begin
                head_adv_c = head_adv_c + H_W'(1);
            end else begin
                head_stop_c = 1'b1;
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        issued_d = issued_q;
        if (flush) begin
            rd_ptr_d = flush_ptr;
            issued_d = '0;
        end else if (en) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(head_adv_c);
            issued_d = issued_nx_c >> head_adv_c;
        end
    end
endmodule

// File: doc/schedule_multi.md
# schedule_multi

Multi-issue schedule stage of the Qu processor. Each cycle it reads a sliding window of consecutive reservation-station entries and selects up to ISSUE_WIDTH ready, not-yet-issued micro-ops, oldest first. Selected micro-ops are written into the issue FIFO, within the free space that FIFO reports. The window base advances past every contiguous issued entry at its head, so one stalled micro-op never holds back the rest of the window. The block sits between the reservation station read ports and the execute-side issue FIFO.

## Interface
Parameters:
- WINDOW, 4: number of reservation-station entries examined per cycle; power of two, 2..16.
- ISSUE_WIDTH, 2: maximum micro-ops issued per cycle; 1..WINDOW.
- CNT_W, $clog2(ISSUE_WIDTH+1): width of the FIFO free-slot count.

Ports (name, direction, width, meaning):
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  stage enable; when low, nothing issues and no state changes.
- flush  input  1  pipeline flush; synchronous, takes priority over en.
- flush_ptr  input  res_st_addr_t  window base loaded on flush.
- res_st_rd_addr[WINDOW]  output  res_st_addr_t  read address for window slot i; always rd_ptr+i, modulo address width.
- res_st_rd_in[WINDOW]  input  res_st_cell_t  reservation-station cell for slot i; read combinationally, same cycle.
- fifo_free  input  CNT_W  number of micro-ops the FIFO accepts this cycle; saturated at ISSUE_WIDTH by the FIFO.
- fifo_wr_en[ISSUE_WIDTH]  output  1  write strobe for issue lane j.
- op_out[ISSUE_WIDTH]  output  res_st_cell_t  micro-op on lane j; all zeros when its strobe is low.
- head_ptr  output  res_st_addr_t  current window base, equal to rd_ptr.
- issue_count  output  CNT_W  number of strobes asserted this cycle.

## Operation
- State:
  - rd_ptr (res_st_addr_t).
  - issued[WINDOW], one bit per slot, relative to rd_ptr.
- Slot i is ready when all of these hold:
  - res_st_rd_in[i].op.optype[0] == 1;
  - !issued[i];
  - qj == 0 and qk == 0.
- Grant limit G = min(ISSUE_WIDTH, fifo_free).
- Grants go to the G lowest-index ready slots.
  - The k-th granted slot (k=0,1,…) drives lane k; lanes are packed with no gaps.
  - Lane order follows slot order, so it is program order.
- Strobes are forced to 0, and op_out forced to 0, when any of these holds: rst, flush, !en, G==0.
- Next issued vector: issued | granted.
- Head advance:
  - H = number of contiguous ones in the next issued vector, counted from slot 0 (0..WINDOW).
  - rd_ptr += H.
  - issued is shifted down by H; the H vacated top bits fill with 0.
- A slot with optype[0]==0 is never ready and never counts as issued, so an empty head slot stalls advance.
- H == WINDOW: rd_ptr += WINDOW and issued clears to all zeros.
- rd_ptr wraps naturally at the res_st_addr_t width; read addresses wrap the same way.
- Flush: rd_ptr <= flush_ptr and issued <= 0. Flush overrides en and any advance in that cycle.
- Reset: rd_ptr <= 0 and issued <= 0. Reset overrides flush.
- en low: state holds and outputs are quiet. Read addresses still track rd_ptr.

## Timing
- Select is combinational: cell inputs → fifo_wr_en/op_out in the same cycle. There is no added latency.
- The FIFO captures lanes at the same clk edge that updates issued and rd_ptr.
- A micro-op granted in cycle t is never re-granted from cycle t+1 onward. A window slide does not cause re-grant either.
- The new rd_ptr drives res_st_rd_addr in cycle t+1; cells for the new slots are evaluated in t+1.
- Reset values:
  - rd_ptr = 0, issued = 0;
  - head_ptr = 0;
  - fifo_wr_en all 0, op_out all 0, issue_count = 0 (outputs also held quiet during the reset cycle).
- fifo_free == 0: no issue; state only holds.
- Wakeup: a qj/qk clearing in cycle t is visible to select in cycle t. The reservation station supplies the updated cell.

## Test plan
- Defaults (WINDOW=4, ISSUE_WIDTH=2); all four slots valid and ready; fifo_free=2.
  - Required: cycle 0 issues slots 0,1 on lanes 0,1 and rd_ptr→2.
  - Cycle 1 issues cells at addresses 2,3, and rd_ptr→4.
- Slot 0 has qj≠0; slots 1–3 ready.
  - Required: lanes carry slots 1,2 and rd_ptr stays 0.
  - Next cycle: slot 3 only.
  - Then slot 0's qj clears: slot 0 issues and rd_ptr→4 in one edge.
- fifo_free=1 with all slots ready.
  - Required: one strobe per cycle, issue_count=1, and rd_ptr advances by 1 each cycle.
  - With fifo_free=0 there are no strobes and state is unchanged.
- rd_ptr at max address−1 (e.g. 14 for 4-bit addresses).
  - Required: read addresses are 14,15,0,1.
  - After issuing all four slots, rd_ptr=2.
- Flush with flush_ptr=9 while two slots are issued and en=1.
  - Required: no strobes that cycle; next cycle rd_ptr=9 and issued=0.
- rst asserted together with flush and ready slots.
  - Required: no strobes; rd_ptr=0 and issued=0 on the next cycle.
- en=0 with ready slots.
  - Required: no strobes and no state change.
